// File: rtl/pixel_fetch.sv
// pixel_fetch: port-B SRAM read master that fetches one frame into a small FIFO
// and presents it to the display shifter as a valid/ready stream.
module pixel_fetch #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned FRAME_WORDS = 1024,
    parameter int unsigned DEPTH       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        abort,
    output logic        start_b,
    output logic        rw_b,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    input  logic        ready_b,
    input  logic [15:0] rd_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STROBE,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_b_q, start_b_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               abort_seen_q, abort_seen_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               pix_valid_q, pix_valid_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];

    logic               push_c;
    logic               pop_c;
    logic               flush_c;

    // Fetch sequencer: one outstanding read, start_b low only while in STROBE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        start_b_d    = 1'b1;
        frame_done_d = 1'b0;
        abort_seen_d = abort_seen_q;
        push_c       = 1'b0;
        flush_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start && !abort) begin
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    flush_c = 1'b1;
                    state_d = S_IDLE;
                end else if ((level_q < FULL_LVL) && ready_b) begin
                    start_b_d    = 1'b0;
                    abort_seen_d = 1'b0;
                    state_d      = S_STROBE;
                end
            end
            S_STROBE: begin
                // ready_b still reflects the previous idle state here; ignore it.
                abort_seen_d = abort;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                abort_seen_d = abort_seen_q | abort;
                if (ready_b) begin
                    push_c = 1'b1;
                    addr_d = addr_q + 16'd1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (abort_seen_q || abort) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                flush_c = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FIFO next state; head word and valid are computed ahead so they can be registered.
    always_comb begin
        pop_c = pix_valid_q & pix_ready;
        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = rd_data;
        end

        if (flush_c) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            pix_valid_d = 1'b0;
            pix_data_d  = pix_data_q;
        end else begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
            rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
            level_d     = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
            pix_valid_d = (level_d != '0);
            // A word pushed into an otherwise empty FIFO becomes the head directly.
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                pix_data_d = rd_data;
            end else begin
                pix_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            start_b_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            start_b_q    <= start_b_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            abort_seen_q <= abort_seen_d;
        end
    end

    // FIFO storage, pointers and registered stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            mem_q       <= mem_d;
        end
    end

    assign start_b    = start_b_q;
    assign rw_b       = 1'b1;
    assign addr_b     = addr_q;
    assign data_b     = 16'h0000;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: three instances with different frame setups,
// a simple SRAM responder and a stream/address monitor.
module tb_pixel_fetch;

    localparam int NI = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NI-1:0]     frame_start;
    logic [NI-1:0]     abort;
    logic [NI-1:0]     start_b;
    logic [NI-1:0]     rw_b;
    logic [15:0]       addr_b  [NI];
    logic [15:0]       data_b  [NI];
    logic [NI-1:0]     ready_b = '1;
    logic [15:0]       rd_data [NI];
    logic [15:0]       pix_data [NI];
    logic [NI-1:0]     pix_valid;
    logic [NI-1:0]     pix_ready;
    logic [NI-1:0]     busy;
    logic [NI-1:0]     frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    int          strobe_cnt [NI];
    int          pop_cnt    [NI];
    int          done_cnt   [NI];
    int          addr_err   [NI];
    int          pop_err    [NI];
    int          lat        [NI];
    logic [15:0] raddr      [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pixel_fetch #(
            .BASE_ADDR   (g == 0 ? 16'h0100 : (g == 1 ? 16'h0000 : 16'hFFFE)),
            .FRAME_WORDS (g == 1 ? 8 : 4),
            .DEPTH       (4)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .frame_start (frame_start[g]),
            .abort       (abort[g]),
            .start_b     (start_b[g]),
            .rw_b        (rw_b[g]),
            .addr_b      (addr_b[g]),
            .data_b      (data_b[g]),
            .ready_b     (ready_b[g]),
            .rd_data     (rd_data[g]),
            .pix_data    (pix_data[g]),
            .pix_valid   (pix_valid[g]),
            .pix_ready   (pix_ready[g]),
            .busy        (busy[g]),
            .frame_done  (frame_done[g])
        );
    end

    function automatic logic [15:0] base_of(input int i);
        case (i)
            0:       return 16'h0100;
            1:       return 16'h0000;
            default: return 16'hFFFE;
        endcase
    endfunction

    function automatic logic [15:0] sram_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // SRAM responder: drops ready_b after the strobe, returns data two cycles later.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) begin
                ready_b[i] = 1'b1;
                lat[i]     = 0;
                rd_data[i] = 16'h0000;
            end else if (!start_b[i]) begin
                ready_b[i] = 1'b0;
                lat[i]     = 2;
                raddr[i]   = addr_b[i];
            end else if (lat[i] > 0) begin
                lat[i] = lat[i] - 1;
                if (lat[i] == 0) begin
                    ready_b[i] = 1'b1;
                    rd_data[i] = sram_word(raddr[i]);
                end
            end
        end
    end

    // Monitor: per-frame strobe addresses, popped words and frame_done pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NI; i++) begin
                if (frame_start[i] && !busy[i]) begin
                    strobe_cnt[i] = 0;
                    pop_cnt[i]    = 0;
                    done_cnt[i]   = 0;
                    addr_err[i]   = 0;
                    pop_err[i]    = 0;
                end
                if (!start_b[i]) begin
                    if (addr_b[i] !== 16'(base_of(i) + 16'(strobe_cnt[i])))
                        addr_err[i] = addr_err[i] + 1;
                    strobe_cnt[i] = strobe_cnt[i] + 1;
                end
                if (pix_valid[i] && pix_ready[i]) begin
                    if (pix_data[i] !== sram_word(16'(base_of(i) + 16'(pop_cnt[i]))))
                        pop_err[i] = pop_err[i] + 1;
                    pop_cnt[i] = pop_cnt[i] + 1;
                end
                if (frame_done[i]) done_cnt[i] = done_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int i);
        frame_start[i] = 1'b1;
        tick(1);
        frame_start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, input string tag);
        int c = 0;
        while ((busy[i] || pix_valid[i]) && c < budget) begin
            tick(1);
            c++;
        end
        check({tag, "_timeout"}, 32'(c < budget), 32'd1);
    endtask

    task automatic wait_strobe(input int i, input int nth, input int budget, input string tag);
        int c = 0;
        while (!(start_b[i] == 1'b0 && strobe_cnt[i] == nth) && c < budget) begin
            tick(1);
            c++;
        end
        check({tag, "_timeout"}, 32'(c < budget), 32'd1);
    endtask

    task automatic check_frame(input int i, input string tag, input int words,
                               input logic [15:0] end_addr);
        check({tag, "_strobes"},   32'(strobe_cnt[i]), 32'(words));
        check({tag, "_addr_seq"},  32'(addr_err[i]),   32'd0);
        check({tag, "_pops"},      32'(pop_cnt[i]),    32'(words));
        check({tag, "_pop_data"},  32'(pop_err[i]),    32'd0);
        check({tag, "_done"},      32'(done_cnt[i]),   32'd1);
        check({tag, "_end_addr"},  32'(addr_b[i]),     32'(end_addr));
        check({tag, "_busy"},      32'(busy[i]),       32'd0);
    endtask

    task automatic check_reset(input int i, input string tag);
        check({tag, "_start_b"},    32'(start_b[i]),    32'd1);
        check({tag, "_rw_b"},       32'(rw_b[i]),       32'd1);
        check({tag, "_addr_b"},     32'(addr_b[i]),     32'd0);
        check({tag, "_data_b"},     32'(data_b[i]),     32'd0);
        check({tag, "_pix_valid"},  32'(pix_valid[i]),  32'd0);
        check({tag, "_pix_data"},   32'(pix_data[i]),   32'd0);
        check({tag, "_busy"},       32'(busy[i]),       32'd0);
        check({tag, "_frame_done"}, 32'(frame_done[i]), 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_start = '0;
        abort       = '0;
        pix_ready   = '0;
        tick(3);
        for (int i = 0; i < NI; i++) check_reset(i, $sformatf("rst%0d", i));
        reset_n = 1'b1;
        tick(2);

        // Basic frame at 0x0100, consumer always ready.
        pix_ready[0] = 1'b1;
        pulse_start(0);
        wait_idle(0, 200, "t1");
        check_frame(0, "t1", 4, 16'h0104);

        // Back-pressure: four reads fill the FIFO, then the fetch stalls.
        pulse_start(1);
        tick(60);
        check("t2_stall_strobes", 32'(strobe_cnt[1]), 32'd4);
        check("t2_stall_start_b", 32'(start_b[1]),    32'd1);
        check("t2_stall_busy",    32'(busy[1]),       32'd1);
        check("t2_stall_valid",   32'(pix_valid[1]),  32'd1);
        check("t2_stall_head",    32'(pix_data[1]),   32'(16'h0000 ^ 16'hA5A5));
        pix_ready[1] = 1'b1;
        wait_idle(1, 300, "t2");
        check_frame(1, "t2", 8, 16'h0008);

        // Address wrap FFFE, FFFF, 0000, 0001.
        pix_ready[2] = 1'b1;
        pulse_start(2);
        wait_idle(2, 200, "t3");
        check_frame(2, "t3", 4, 16'h0002);

        // frame_start mid-frame is ignored.
        pulse_start(0);
        tick(6);
        pulse_start(0);
        wait_idle(0, 200, "t5");
        check_frame(0, "t5", 4, 16'h0104);
        tick(5);
        check("t5_no_restart", 32'(busy[0]),     32'd0);
        check("t5_done_once",  32'(done_cnt[0]), 32'd1);

        // Abort during WAIT of the third read: read completes, FIFO flushed.
        pix_ready[0] = 1'b0;
        pulse_start(0);
        wait_strobe(0, 2, 100, "t4_strobe");
        tick(1);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        check("t4_valid_before", 32'(pix_valid[0]), 32'd1);
        tick(2);
        check("t4_busy",     32'(busy[0]),       32'd0);
        check("t4_valid",    32'(pix_valid[0]),  32'd0);
        check("t4_end_addr", 32'(addr_b[0]),     32'h0103);
        check("t4_no_done",  32'(done_cnt[0]),   32'd0);
        tick(10);
        check("t4_strobes",  32'(strobe_cnt[0]), 32'd3);
        check("t4_idle",     32'(busy[0]),       32'd0);

        // Asynchronous reset in the middle of WAIT, then a fresh frame.
        pix_ready[0] = 1'b1;
        pulse_start(0);
        wait_strobe(0, 1, 100, "t6_strobe");
        tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset(0, "t6");
        tick(2);
        reset_n = 1'b1;
        tick(2);
        pulse_start(0);
        wait_idle(0, 200, "t6");
        check_frame(0, "t6", 4, 16'h0104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
